// File: rtl/lcd_hvline_writer.sv
// Turns one horizontal/vertical run into an ST7789 byte stream (CASET, RASET, RAMWR, RGB565 pixels).
// Optional LCD_HVLINE_CLIP_EN: clip runs to the WIDTH x HEIGHT panel, adding one cycle before CASET.
module lcd_hvline_writer #(
    parameter int WIDTH    = 240,
    parameter int HEIGHT   = 240,
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hvline_plot,
    output logic        hvline_busy,
    input  logic [15:0] hvline_x,
    input  logic [15:0] hvline_y,
    input  logic [15:0] hvline_len,
    input  logic [15:0] hvline_color,
    input  logic        hvline_vertical,
    output logic [7:0]  out_data,
    output logic        out_dc,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CASET = 3'd1;
    localparam logic [2:0] S_RASET = 3'd2;
    localparam logic [2:0] S_RAMWR = 3'd3;
    localparam logic [2:0] S_PIXEL = 3'd4;
    localparam logic [2:0] S_CLIP  = 3'd5;

    localparam logic [15:0] X_OFF16 = 16'(X_OFFSET);
    localparam logic [15:0] Y_OFF16 = 16'(Y_OFFSET);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0] color_q, color_d;
    logic        busy_q, busy_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_dc_q, out_dc_d;
    logic        out_last_q, out_last_d;
    logic        accept, fire, drop, emit;

`ifdef LCD_HVLINE_CLIP_EN
    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(HEIGHT);
    logic [15:0] x_q, x_d, y_q, y_d, len_q, len_d;
    logic        vert_q, vert_d;
    logic [15:0] avail, clip_len;

    // Start is known on-panel here, so the remaining span cannot underflow.
    assign avail    = vert_q ? (H16 - y_q) : (W16 - x_q);
    assign clip_len = (len_q > avail) ? avail : len_q;
    assign drop     = (hvline_len == 16'd0) || (hvline_x >= W16) || (hvline_y >= H16);
`else
    assign drop     = (hvline_len == 16'd0);
`endif

    assign accept      = hvline_plot && (state_q == S_IDLE);
    assign fire        = out_valid_q && out_ready;
    assign hvline_busy = busy_q | accept;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        color_d     = color_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_dc_d    = out_dc_q;
        out_last_d  = out_last_q;
        emit        = 1'b0;
`ifdef LCD_HVLINE_CLIP_EN
        x_d    = x_q;
        y_d    = y_q;
        len_d  = len_q;
        vert_d = vert_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept && !drop) begin
                    busy_d  = 1'b1;
                    color_d = hvline_color;
`ifdef LCD_HVLINE_CLIP_EN
                    x_d     = hvline_x;
                    y_d     = hvline_y;
                    len_d   = hvline_len;
                    vert_d  = hvline_vertical;
                    state_d = S_CLIP;
`else
                    xs_d    = hvline_x + X_OFF16;
                    ys_d    = hvline_y + Y_OFF16;
                    xe_d    = hvline_vertical ? xs_d : (xs_d + hvline_len - 16'd1);
                    ye_d    = hvline_vertical ? (ys_d + hvline_len - 16'd1) : ys_d;
                    cnt_d   = hvline_len;
                    state_d = S_CASET;
                    idx_d   = 3'd0;
                    emit    = 1'b1;
`endif
                end
            end
`ifdef LCD_HVLINE_CLIP_EN
            S_CLIP: begin
                xs_d    = x_q + X_OFF16;
                ys_d    = y_q + Y_OFF16;
                xe_d    = vert_q ? xs_d : (xs_d + clip_len - 16'd1);
                ye_d    = vert_q ? (ys_d + clip_len - 16'd1) : ys_d;
                cnt_d   = clip_len;
                state_d = S_CASET;
                idx_d   = 3'd0;
                emit    = 1'b1;
            end
`endif
            S_CASET, S_RASET, S_RAMWR, S_PIXEL: begin
                if (fire) begin
                    emit = 1'b1;
                    case (state_q)
                        S_CASET: begin
                            if (idx_q == 3'd4) begin
                                state_d = S_RASET;
                                idx_d   = 3'd0;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        S_RASET: begin
                            if (idx_q == 3'd4) begin
                                state_d = S_RAMWR;
                                idx_d   = 3'd0;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        S_RAMWR: begin
                            state_d = S_PIXEL;
                            idx_d   = 3'd0;
                        end
                        default: begin
                            if (idx_q == 3'd0) begin
                                idx_d = 3'd1;
                            end else if (cnt_q == 16'd1) begin
                                emit        = 1'b0;
                                state_d     = S_IDLE;
                                busy_d      = 1'b0;
                                out_valid_d = 1'b0;
                                out_last_d  = 1'b0;
                            end else begin
                                idx_d = 3'd0;
                                cnt_d = cnt_q - 16'd1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        // Byte presented next is a pure function of the position being entered.
        if (emit) begin
            out_valid_d = 1'b1;
            out_dc_d    = 1'b1;
            out_last_d  = 1'b0;
            case (state_d)
                S_CASET, S_RASET: begin
                    case (idx_d)
                        3'd0: begin
                            out_data_d = (state_d == S_CASET) ? 8'h2A : 8'h2B;
                            out_dc_d   = 1'b0;
                        end
                        3'd1:    out_data_d = (state_d == S_CASET) ? xs_d[15:8] : ys_d[15:8];
                        3'd2:    out_data_d = (state_d == S_CASET) ? xs_d[7:0]  : ys_d[7:0];
                        3'd3:    out_data_d = (state_d == S_CASET) ? xe_d[15:8] : ye_d[15:8];
                        default: out_data_d = (state_d == S_CASET) ? xe_d[7:0]  : ye_d[7:0];
                    endcase
                end
                S_RAMWR: begin
                    out_data_d = 8'h2C;
                    out_dc_d   = 1'b0;
                end
                default: begin
                    out_data_d = (idx_d == 3'd0) ? color_d[15:8] : color_d[7:0];
                    out_last_d = (idx_d != 3'd0) && (cnt_d == 16'd1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= 16'd0;
            xs_q        <= 16'd0;
            xe_q        <= 16'd0;
            ys_q        <= 16'd0;
            ye_q        <= 16'd0;
            color_q     <= 16'd0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_dc_q    <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef LCD_HVLINE_CLIP_EN
            x_q    <= 16'd0;
            y_q    <= 16'd0;
            len_q  <= 16'd0;
            vert_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            color_q     <= color_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_dc_q    <= out_dc_d;
            out_last_q  <= out_last_d;
`ifdef LCD_HVLINE_CLIP_EN
            x_q    <= x_d;
            y_q    <= y_d;
            len_q  <= len_d;
            vert_q <= vert_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_dc    = out_dc_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_lcd_hvline_writer.sv
// Bench for lcd_hvline_writer: byte-stream model from run fields, per-byte compare, literal pins.
module tb_lcd_hvline_writer;

    localparam int W = 240;
    localparam int H = 240;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        hvline_plot = 1'b0;
    logic        hvline_busy;
    logic [15:0] hx = 16'd0, hy = 16'd0, hlen = 16'd0, hcol = 16'd0;
    logic        hvert = 1'b0;
    logic [7:0]  out_data;
    logic        out_dc, out_last, out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic [7:0] log_data[$];
    logic [7:0] prev_data = 8'h00;
    logic       prev_dc = 1'b0, prev_last = 1'b0, prev_stall = 1'b0;
    bit         rand_mode = 1'b0;
    logic       ready_fixed = 1'b1;

    logic [7:0] lit_h[21] = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0E, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h14, 8'h2C,
                              8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00};
    logic [7:0] lit_v[13] = '{8'h2A, 8'h00, 8'h03, 8'h00, 8'h03, 8'h2B, 8'h00, 8'h64, 8'h00, 8'h64, 8'h2C,
                              8'h07, 8'hE0};

    lcd_hvline_writer dut (
        .clk(clk), .resetn(resetn), .hvline_plot(hvline_plot), .hvline_busy(hvline_busy),
        .hvline_x(hx), .hvline_y(hy), .hvline_len(hlen), .hvline_color(hcol),
        .hvline_vertical(hvert), .out_data(out_data), .out_dc(out_dc), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected stream straight from the command format: window, RAMWR, L colour pairs.
    function automatic int model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] len,
                                 input logic v, input logic [15:0] c);
        int L;
        logic [15:0] xs, ys, xe, ye;
        L = int'(len);
`ifdef LCD_HVLINE_CLIP_EN
        if (int'(x) >= W || int'(y) >= H) L = 0;
        else if (v && L > H - int'(y)) L = H - int'(y);
        else if (!v && L > W - int'(x)) L = W - int'(x);
`endif
        if (L == 0) return 0;
        xs = x;
        ys = y;
        xe = v ? xs : 16'(int'(xs) + L - 1);
        ye = v ? 16'(int'(ys) + L - 1) : ys;
        exp_q.push_back({8'h2A, 2'b00});
        exp_q.push_back({xs[15:8], 2'b10});
        exp_q.push_back({xs[7:0], 2'b10});
        exp_q.push_back({xe[15:8], 2'b10});
        exp_q.push_back({xe[7:0], 2'b10});
        exp_q.push_back({8'h2B, 2'b00});
        exp_q.push_back({ys[15:8], 2'b10});
        exp_q.push_back({ys[7:0], 2'b10});
        exp_q.push_back({ye[15:8], 2'b10});
        exp_q.push_back({ye[7:0], 2'b10});
        exp_q.push_back({8'h2C, 2'b00});
        for (int i = 0; i < L; i++) begin
            exp_q.push_back({c[15:8], 2'b10});
            exp_q.push_back({c[7:0], 1'b1, (i == L - 1)});
        end
        return L;
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else if (out_valid) begin
            if (prev_stall)
                chk("stall_hold", {22'd0, out_data, out_dc, out_last}, {22'd0, prev_data, prev_dc, prev_last});
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h want none", out_data);
                end else begin
                    chk("byte", {22'd0, out_data, out_dc, out_last}, {22'd0, exp_q.pop_front()});
                end
                log_data.push_back(out_data);
            end
            prev_stall = !out_ready;
            prev_data  = out_data;
            prev_dc    = out_dc;
            prev_last  = out_last;
        end else begin
            if (prev_stall) chk("valid_held_in_stall", 32'(out_valid), 32'd1);
            prev_stall = 1'b0;
        end
    end

    task automatic do_plot(input logic [15:0] x, input logic [15:0] y, input logic [15:0] len,
                           input logic v, input logic [15:0] c);
        int L;
        @(posedge clk);
        #2;
        log_data.delete();
        hx = x; hy = y; hlen = len; hvert = v; hcol = c;
        hvline_plot = 1'b1;
        #1 chk("busy_on_accept", 32'(hvline_busy), 32'd1);
        L = model(x, y, len, v, c);
        @(posedge clk);
        #2 hvline_plot = 1'b0;
`ifdef LCD_HVLINE_CLIP_EN
        chk("valid_clip_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
`endif
        chk("valid_latency", 32'(out_valid), 32'(L > 0));
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("run_timeout", 32'(n < 300), 32'd1);
        chk("busy_after_run", 32'(hvline_busy), 32'd0);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_dc", 32'(out_dc), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(hvline_busy), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        do_plot(16'd10, 16'd20, 16'd5, 1'b0, 16'hF800);
        wait_done();
        chk("h_count", 32'(log_data.size()), 32'd21);
        for (int i = 0; i < 21 && i < log_data.size(); i++) chk("h_literal", 32'(log_data[i]), 32'(lit_h[i]));

        do_plot(16'd3, 16'd100, 16'd1, 1'b1, 16'h07E0);
        wait_done();
        chk("v_count", 32'(log_data.size()), 32'd13);
        for (int i = 0; i < 13 && i < log_data.size(); i++) chk("v_literal", 32'(log_data[i]), 32'(lit_v[i]));

        rand_mode = 1'b1;
        do_plot(16'd100, 16'd7, 16'd7, 1'b0, 16'h1234);
        wait_done();
        rand_mode = 1'b0;
        chk("bp_count", 32'(log_data.size()), 32'd25);

        do_plot(16'd1, 16'd1, 16'd0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("len0_busy", 32'(hvline_busy), 32'd0);
            chk("len0_valid", 32'(out_valid), 32'd0);
        end

        do_plot(16'd0, 16'd0, 16'd3, 1'b0, 16'h00FF);
        repeat (4) @(posedge clk);
        #2;
        hx = 16'd7; hlen = 16'd9; hvline_plot = 1'b1;
        #1 chk("busy_during_run", 32'(hvline_busy), 32'd1);
        @(posedge clk);
        #2 hvline_plot = 1'b0;
        wait_done();
        chk("ignored_plot_count", 32'(log_data.size()), 32'd17);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_second_run", 32'(out_valid), 32'd0);
        end

        do_plot(16'd50, 16'd60, 16'd4, 1'b0, 16'h1234);
        n = 0;
        while (log_data.size() < 7 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("reach_byte8", 32'(n < 100), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(hvline_busy), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_last", 32'(out_last), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        do_plot(16'd5, 16'd6, 16'd2, 1'b1, 16'hABCD);
        wait_done();
        chk("fresh_count", 32'(log_data.size()), 32'd15);

        do_plot(16'd238, 16'd0, 16'd10, 1'b0, 16'h5555);
        wait_done();
`ifdef LCD_HVLINE_CLIP_EN
        chk("clip_count", 32'(log_data.size()), 32'd15);
        if (log_data.size() > 4) chk("clip_xe_lo", 32'(log_data[4]), 32'hEF);
        do_plot(16'd240, 16'd0, 16'd10, 1'b0, 16'h5555);
        wait_done();
        chk("clip_drop_count", 32'(log_data.size()), 32'd0);
`else
        chk("wrap_count", 32'(log_data.size()), 32'd31);
        if (log_data.size() > 4) chk("wrap_xe_lo", 32'(log_data[4]), 32'hF7);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
